ucie_ctl_sb_tx: RTL
===================

Name: ucie_ctl_sb_tx

Overview:
- Sideband transmit stage of the UCIe controller.
- Accepts a one-hot-free message select from the RDI/link FSM and builds the 64-bit header. For advertised-capability messages it also builds the 64-bit data payload.
- Computes control parity (cp) and data parity (dp), gates transmission on credits, and serializes the message MSB-chunk-first in N-bit beats.
- It drives the same i_pl_cfg_vld / N-bit data interface that ucie_ctl_sb_rx consumes, and receives that block's o_cfg_crd credit returns.

Parameters:
N, 16, beat width in bits; legal values 16 or 32.
CRD_MAX, 4, credits available after reset (remote RX buffer depth); 1..15.

Ports:
i_clk  input  1  clock.
i_rst  input  1  reset, synchronous, active-high.
i_msg_vld  input  1  message request; held until o_msg_ack or o_msg_err.
i_msg_sel  input  5  message select (encoding in package).
i_adv_cap_value  input  32  capability value; sampled on accept of ADVCAP.
i_pl_cfg_crd  input  1  one-cycle credit return pulse from remote RX.
o_pl_cfg  output  N  serialized beat; 0 when o_pl_cfg_vld=0.
o_pl_cfg_vld  output  1  beat valid.
o_msg_ack  output  1  one-cycle pulse, request accepted.
o_msg_err  output  1  one-cycle pulse, unsupported i_msg_sel (dropped).
o_busy  output  1  high from accept through last beat.
o_crd_cnt  output  4  current credit count.
o_crd_ovf  output  1  one-cycle pulse, credit return while count=CRD_MAX.

Behaviour:
- Reset (i_rst=1 at posedge):
  - FSM returns to IDLE; credits=CRD_MAX.
  - All other outputs 0; any in-flight message is abandoned with no further beats.
- Header phase0, bit fields:
  - [31:29] src_id=3'b001; [28:22] zero; [21:14] msg_code; [13:5] zero; [4:0] opcode.
  - opcode=5'b10010 without data, 5'b11011 with data.
- Header phase1, bit fields:
  - [31] dp; [30] cp; [29:27] zero; [26:24] dst_id=3'b101; [23:8] msg_info=0; [7:0] msg_subcode.
- Data phases (ADVCAP only): phase2=i_adv_cap_value, phase3=32'h0.
- Parity:
  - cp = XOR of all phase0 and phase1 bits excluding [31:30].
  - dp = XOR of all data bits; dp=0 for messages without data.
- Message select, in the form sel: code/subcode:
  - 1 REQ_ACTIVE 0x03/0x01; 2 REQ_LINKRESET 0x03/0x09; 3 RSP_ACTIVE 0x04/0x01; 4 RSP_LINKRESET 0x04/0x09.
  - 5 ERR_CE 0x09/0x00; 6 ERR_NF 0x09/0x01; 7 ERR_F 0x09/0x02; 8 ADVCAP 0x01/0x00 (with data).
  - All other values are unsupported.
- FSM IDLE:
  - If i_msg_vld and the sel is supported and credits>0: pulse o_msg_ack, load a 128-bit shift register, decrement credit, go to SEND.
  - If i_msg_vld and the sel is unsupported: pulse o_msg_err, consume no credit, stay in IDLE.
  - If credits=0: no ack; the request waits.
- FSM SEND:
  - First beat is valid the cycle after ack.
  - Beat order: phase0[31:32-N] first, continuing MSB-first through phase1, phase2, phase3.
  - Beat count is 64/N without data, 128/N with data.
  - After the last beat go to GAP.
- FSM GAP: one cycle with o_pl_cfg_vld=0, then IDLE. Earliest next ack is the cycle after GAP, so consecutive messages are separated by at least 2 idle beats.
- o_busy is high in SEND and GAP.
- Credits:
  - +1 on i_pl_cfg_crd; -1 on accept; both in the same cycle leaves the count unchanged.
  - A return at CRD_MAX with no simultaneous accept saturates the count and pulses o_crd_ovf.
  - A return while credits=0 and i_msg_vld is pending is usable for accept on the next cycle (credit check uses the registered count).
- i_msg_sel and i_adv_cap_value are ignored outside the accept cycle. Changes during SEND do not affect the beats.

Decomposition:
- Package ucie_ctl_sb_pkg holds:
  - opcode, src/dst id, msg_code and subcode constants;
  - the i_msg_sel encoding;
  - header field bit positions.
- The package is shared with ucie_ctl_sb_rx.
- Sub-module ucie_ctl_sb_msg_builder is combinational: sel + cap value -> 128-bit message, has_data, supported flag, with parity computed inside.
- The top holds the FSM, beat counter, shift register and credit counter.

Test Plan:
- N=16, REQ_ACTIVE after reset -> ack at T, beats T+1..T+4 = 0x2000, 0xC012, 0x0500, 0x0001; vld low at T+5; o_crd_cnt 4->3.
- ADVCAP with cap=0x00000001 -> 8 beats: 0x2000, 0x401B, 0x8500, 0x0000, 0x0000, 0x0001, 0x0000, 0x0000 (dp=1, cp=0).
- ERR_NF -> beats 0x2002, 0x4012, 0x0500, 0x0001. i_msg_sel=0x1F -> o_msg_err pulse, no vld, credit unchanged.
- Five REQ_ACTIVE requests with no credit return -> four sent, fifth stalls with o_crd_cnt=0. A single i_pl_cfg_crd pulse -> fifth is acked the next cycle.
- Credit return coinciding with accept -> count unchanged. Return at count=4 -> o_crd_ovf=1, count stays 4.
- i_rst asserted at beat 2 of ADVCAP -> next cycle vld=0, busy=0, o_crd_cnt=4. A fresh REQ_ACTIVE then transmits normally.

Source files
------------

// File: rtl/ucie_ctl_sb_pkg.sv
// Shared sideband definitions: message select encoding, header constants and field positions.
// Used by both the sideband transmit and receive stages.
package ucie_ctl_sb_pkg;

    localparam logic [2:0] SB_SRC_ID      = 3'b001;
    localparam logic [2:0] SB_DST_ID      = 3'b101;
    localparam logic [4:0] SB_OPC_NODATA  = 5'b10010;
    localparam logic [4:0] SB_OPC_DATA    = 5'b11011;

    localparam logic [7:0] MSG_CODE_REQ    = 8'h03;
    localparam logic [7:0] MSG_CODE_RSP    = 8'h04;
    localparam logic [7:0] MSG_CODE_ERR    = 8'h09;
    localparam logic [7:0] MSG_CODE_ADVCAP = 8'h01;

    localparam logic [7:0] SUB_ACTIVE      = 8'h01;
    localparam logic [7:0] SUB_LINKRESET   = 8'h09;
    localparam logic [7:0] SUB_ERR_CE      = 8'h00;
    localparam logic [7:0] SUB_ERR_NF      = 8'h01;
    localparam logic [7:0] SUB_ERR_F       = 8'h02;
    localparam logic [7:0] SUB_ADVCAP      = 8'h00;

    // phase0 field positions
    localparam int HDR_SRC_MSB  = 31;
    localparam int HDR_SRC_LSB  = 29;
    localparam int HDR_CODE_MSB = 21;
    localparam int HDR_CODE_LSB = 14;
    localparam int HDR_OPC_MSB  = 4;
    localparam int HDR_OPC_LSB  = 0;

    // phase1 field positions
    localparam int HDR_DP_BIT   = 31;
    localparam int HDR_CP_BIT   = 30;
    localparam int HDR_DST_MSB  = 26;
    localparam int HDR_DST_LSB  = 24;
    localparam int HDR_SUB_MSB  = 7;
    localparam int HDR_SUB_LSB  = 0;

    typedef enum logic [4:0] {
        SEL_REQ_ACTIVE    = 5'd1,
        SEL_REQ_LINKRESET = 5'd2,
        SEL_RSP_ACTIVE    = 5'd3,
        SEL_RSP_LINKRESET = 5'd4,
        SEL_ERR_CE        = 5'd5,
        SEL_ERR_NF        = 5'd6,
        SEL_ERR_F         = 5'd7,
        SEL_ADVCAP        = 5'd8
    } msg_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } tx_state_e;

endpackage

// File: rtl/ucie_ctl_sb_msg_builder.sv
// Combinational sideband message builder: select + capability value -> 128-bit message
// laid out {phase0, phase1, phase2, phase3}, with cp/dp filled into phase1.
module ucie_ctl_sb_msg_builder
    import ucie_ctl_sb_pkg::*;
(
    input  logic [4:0]   i_sel,
    input  logic [31:0]  i_cap,
    output logic [127:0] o_msg,
    output logic         o_has_data,
    output logic         o_supported
);

    logic [7:0]  code;
    logic [7:0]  sub;
    logic [31:0] p0;
    logic [31:0] p1;
    logic [31:0] d2;

    always_comb begin
        code        = 8'h00;
        sub         = 8'h00;
        o_supported = 1'b1;
        o_has_data  = 1'b0;
        case (i_sel)
            SEL_REQ_ACTIVE:    begin code = MSG_CODE_REQ;    sub = SUB_ACTIVE;    end
            SEL_REQ_LINKRESET: begin code = MSG_CODE_REQ;    sub = SUB_LINKRESET; end
            SEL_RSP_ACTIVE:    begin code = MSG_CODE_RSP;    sub = SUB_ACTIVE;    end
            SEL_RSP_LINKRESET: begin code = MSG_CODE_RSP;    sub = SUB_LINKRESET; end
            SEL_ERR_CE:        begin code = MSG_CODE_ERR;    sub = SUB_ERR_CE;    end
            SEL_ERR_NF:        begin code = MSG_CODE_ERR;    sub = SUB_ERR_NF;    end
            SEL_ERR_F:         begin code = MSG_CODE_ERR;    sub = SUB_ERR_F;     end
            SEL_ADVCAP: begin
                code       = MSG_CODE_ADVCAP;
                sub        = SUB_ADVCAP;
                o_has_data = 1'b1;
            end
            default: o_supported = 1'b0;
        endcase

        p0 = '0;
        p0[HDR_SRC_MSB:HDR_SRC_LSB]   = SB_SRC_ID;
        p0[HDR_CODE_MSB:HDR_CODE_LSB] = code;
        p0[HDR_OPC_MSB:HDR_OPC_LSB]   = o_has_data ? SB_OPC_DATA : SB_OPC_NODATA;

        p1 = '0;
        p1[HDR_DST_MSB:HDR_DST_LSB] = SB_DST_ID;
        p1[HDR_SUB_MSB:HDR_SUB_LSB] = sub;

        d2 = o_has_data ? i_cap : 32'h0;

        // parity bits are still zero here, so folding all of p1 excludes them
        p1[HDR_CP_BIT] = (^p0) ^ (^p1);
        p1[HDR_DP_BIT] = ^d2;

        o_msg = {p0, p1, d2, 32'h0};
    end

endmodule

// File: rtl/ucie_ctl_sb_tx.sv
// Sideband transmit stage: accepts a message request, gates it on remote-RX credits,
// and serializes the header (and ADVCAP payload) MSB-first in N-bit beats.
module ucie_ctl_sb_tx
    import ucie_ctl_sb_pkg::*;
#(
    parameter int N       = 16,
    parameter int CRD_MAX = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_msg_vld,
    input  logic [4:0]   i_msg_sel,
    input  logic [31:0]  i_adv_cap_value,
    input  logic         i_pl_cfg_crd,
    output logic [N-1:0] o_pl_cfg,
    output logic         o_pl_cfg_vld,
    output logic         o_msg_ack,
    output logic         o_msg_err,
    output logic         o_busy,
    output logic [3:0]   o_crd_cnt,
    output logic         o_crd_ovf
);

    localparam logic [2:0] BEATS_HDR_M1 = 3'(64 / N - 1);
    localparam logic [2:0] BEATS_ALL_M1 = 3'(128 / N - 1);
    localparam logic [3:0] CRD_FULL     = 4'(CRD_MAX);

    tx_state_e    state;
    tx_state_e    state_nxt;
    logic [127:0] msg;
    logic         has_data;
    logic         supported;
    logic [127:0] shreg;
    logic [2:0]   beat_left;
    logic [3:0]   crd;
    logic         accept;

    ucie_ctl_sb_msg_builder u_builder (
        .i_sel       (i_msg_sel),
        .i_cap       (i_adv_cap_value),
        .o_msg       (msg),
        .o_has_data  (has_data),
        .o_supported (supported)
    );

    // Credit check uses the registered count, so a same-cycle return does not enable accept.
    assign accept = !i_rst && (state == ST_IDLE) && i_msg_vld && supported && (crd != 4'd0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_SEND;
            ST_SEND: if (beat_left == 3'd0) state_nxt = ST_GAP;
            ST_GAP:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_pl_cfg_vld = (state == ST_SEND);
        o_busy       = (state == ST_SEND) || (state == ST_GAP);
        o_msg_ack    = accept;
        o_msg_err    = !i_rst && (state == ST_IDLE) && i_msg_vld && !supported;
        o_crd_ovf    = !i_rst && i_pl_cfg_crd && !accept && (crd == CRD_FULL);
        o_pl_cfg     = o_pl_cfg_vld ? shreg[127 -: N] : '0;
        o_crd_cnt    = crd;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shreg     <= '0;
            beat_left <= '0;
        end else if (accept) begin
            shreg     <= msg;
            beat_left <= has_data ? BEATS_ALL_M1 : BEATS_HDR_M1;
        end else if (state == ST_SEND) begin
            shreg     <= shreg << N;
            beat_left <= beat_left - 3'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            crd <= CRD_FULL;
        end else begin
            case ({i_pl_cfg_crd, accept})
                2'b10:   if (crd != CRD_FULL) crd <= crd + 4'd1;
                2'b01:   crd <= crd - 4'd1;
                default: crd <= crd;
            endcase
        end
    end

endmodule
